abft_locate_correct: RTL and testbench

- Downstream stage of the 4x4 ABFT matrix-multiply block.
- Consumes the 16 product elements and the expected row/column checksums derived from the X/Y operands.
- Sequentially recomputes actual row and column sums, then locates a single faulty element and corrects it in place.
- Reports a classified status: clean, corrected, checksum-only error, or uncorrectable.

---
 rtl/abft_locate_correct.sv | 190 +++++++++++++++++++
 tb/tb_abft_locate_correct.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/abft_locate_correct.sv
// ABFT locate/correct stage: recomputes row/column sums of a 4x4 product,
// locates a single faulty element against the expected checksums and fixes it.
module abft_locate_correct #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [16*DW-1:0] z_flat,
  input  logic [4*CW-1:0]  exp_row,
  input  logic [4*CW-1:0]  exp_col,
  output logic [16*DW-1:0] zc_flat,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [1:0]       err_row,
  output logic [1:0]       err_col
);

  localparam int unsigned DTW = CW + 1;
  localparam int unsigned FW  = CW + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROW    = 2'd1;
  localparam logic [1:0] S_COL    = 2'd2;
  localparam logic [1:0] S_DECIDE = 2'd3;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
  localparam logic [1:0] ST_CKSUM  = 2'b11;

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_cnt;
  logic [16*DW-1:0] r_z;
  logic [4*CW-1:0]  r_exp_row, r_exp_col;
  logic [CW-1:0]    r_sum;
  logic             r_sum_vld, r_sum_col;
  logic [1:0]       r_sum_idx;
  logic [3:0]       r_row_miss, r_col_miss;
  logic [DTW-1:0]   r_row_delta [4];
  logic [DTW-1:0]   r_col_delta [4];

  logic [CW-1:0]    w_sum;
  logic [CW-1:0]    w_exp_sel;
  logic [DTW-1:0]   w_delta;
  logic [2:0]       w_nr, w_nc;
  logic [1:0]       w_er, w_ec;
  logic [DTW-1:0]   w_delta_r, w_delta_c;
  logic [DW-1:0]    w_zsel;
  logic [FW-1:0]    w_fix;
  logic             w_fix_ok;
  logic [1:0]       w_status;
  logic [16*DW-1:0] w_zc;
  logic             w_decide;

  // Sum of the row or column selected by the line counter
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < 4; t++) begin
      if (r_state == S_COL) w_sum = w_sum + CW'(r_z[DW*(4*t + 32'(r_cnt)) +: DW]);
      else                  w_sum = w_sum + CW'(r_z[DW*(4*32'(r_cnt) + t) +: DW]);
    end
  end

  // Compare stage runs one cycle behind the summation
  always_comb begin
    w_exp_sel = r_sum_col ? r_exp_col[CW*r_sum_idx +: CW] : r_exp_row[CW*r_sum_idx +: CW];
    w_delta   = DTW'(w_exp_sel) - DTW'(r_sum);
  end

  // Classification from the per-line mismatch flags and deltas
  always_comb begin
    w_nr = 3'($countones(r_row_miss));
    w_nc = 3'($countones(r_col_miss));
    w_er = 2'd0;
    w_ec = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_row_miss[i]) w_er = 2'(i);
      if (r_col_miss[i]) w_ec = 2'(i);
    end
    w_delta_r = r_row_delta[w_er];
    w_delta_c = r_col_delta[w_ec];
    w_zsel    = r_z[DW*(4*32'(w_er) + 32'(w_ec)) +: DW];
    w_fix     = FW'(w_zsel) + {{(FW-DTW){w_delta_r[DTW-1]}}, w_delta_r};
    w_fix_ok  = (w_fix[FW-1:DW] == '0);
    w_zc      = r_z;
    if (w_nr == 3'd0 && w_nc == 3'd0) begin
      w_status = ST_CLEAN;
    end else if (w_nr == 3'd1 && w_nc == 3'd1 && w_delta_r == w_delta_c && w_fix_ok) begin
      w_status = ST_CORR;
      w_zc[DW*(4*32'(w_er) + 32'(w_ec)) +: DW] = w_fix[DW-1:0];
    end else if ((w_nr == 3'd1 && w_nc == 3'd0) || (w_nr == 3'd0 && w_nc == 3'd1)) begin
      w_status = ST_CKSUM;
    end else begin
      w_status = ST_UNCORR;
    end
  end

  // DECIDE waits until the last column compare has landed
  assign w_decide = (r_state == S_DECIDE) && !r_sum_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && !busy) w_state_nxt = S_ROW;
      S_ROW:    if (r_cnt == 2'd3)  w_state_nxt = S_COL;
      S_COL:    if (r_cnt == 2'd3)  w_state_nxt = S_DECIDE;
      S_DECIDE: if (!r_sum_vld)     w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_z        <= '0;
      r_exp_row  <= '0;
      r_exp_col  <= '0;
      r_sum      <= '0;
      r_sum_vld  <= 1'b0;
      r_sum_col  <= 1'b0;
      r_sum_idx  <= '0;
      r_row_miss <= '0;
      r_col_miss <= '0;
      for (int i = 0; i < 4; i++) begin
        r_row_delta[i] <= '0;
        r_col_delta[i] <= '0;
      end
      zc_flat    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= '0;
      err_row    <= '0;
      err_col    <= '0;
    end else begin
      done      <= 1'b0;
      r_sum_vld <= 1'b0;
      if (r_sum_vld) begin
        if (r_sum_col) begin
          r_col_miss[r_sum_idx]  <= (w_delta != '0);
          r_col_delta[r_sum_idx] <= w_delta;
        end else begin
          r_row_miss[r_sum_idx]  <= (w_delta != '0);
          r_row_delta[r_sum_idx] <= w_delta;
        end
      end
      case (r_state)
        S_IDLE: begin
          // busy stays up through the done cycle so a start there is dropped
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            r_z        <= z_flat;
            r_exp_row  <= exp_row;
            r_exp_col  <= exp_col;
            r_cnt      <= '0;
            r_row_miss <= '0;
            r_col_miss <= '0;
            busy       <= 1'b1;
          end
        end
        S_ROW, S_COL: begin
          r_sum     <= w_sum;
          r_sum_vld <= 1'b1;
          r_sum_col <= (r_state == S_COL);
          r_sum_idx <= r_cnt;
          r_cnt     <= r_cnt + 2'd1;
        end
        S_DECIDE: begin
          if (w_decide) begin
            zc_flat <= w_zc;
            status  <= w_status;
            err_row <= w_er;
            err_col <= w_ec;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abft_locate_correct.sv
// Bench for abft_locate_correct: directed spec cases plus randomized fault
// injection checked against an integer-level checksum model.
module tb_abft_locate_correct;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [16*DW-1:0] z_flat;
  logic [4*CW-1:0]  exp_row;
  logic [4*CW-1:0]  exp_col;
  logic [16*DW-1:0] zc_flat;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [1:0]       err_row;
  logic [1:0]       err_col;

  abft_locate_correct #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .z_flat(z_flat),
    .exp_row(exp_row), .exp_col(exp_col), .zc_flat(zc_flat),
    .busy(busy), .done(done), .status(status),
    .err_row(err_row), .err_col(err_col)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_z  [4][4];
  int m_er [4];
  int m_ec [4];
  int e_zc [4][4];
  int e_st, e_er, e_ec;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_ref();
    int zr [4][4] = '{'{150,200,250,300}, '{60,80,100,120}, '{120,160,200,240}, '{90,120,150,180}};
    int rr [4] = '{900,360,720,540};
    int cc [4] = '{420,560,700,840};
    m_z = zr; m_er = rr; m_ec = cc;
  endtask

  // Expected checksums that match the current matrix exactly
  task automatic exp_from_z();
    for (int i = 0; i < 4; i++) begin
      m_er[i] = 0; m_ec[i] = 0;
      for (int j = 0; j < 4; j++) begin
        m_er[i] += m_z[i][j];
        m_ec[i] += m_z[j][i];
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) z_flat[DW*(4*i+j) +: DW] = 16'(m_z[i][j]);
      exp_row[CW*i +: CW] = 18'(m_er[i]);
      exp_col[CW*i +: CW] = 18'(m_ec[i]);
    end
  endtask

  // Reference: rules of the locate/correct classification on plain integers
  task automatic model();
    int ar [4];
    int ac [4];
    int dr [4];
    int dc [4];
    int nr, nc, v;
    nr = 0; nc = 0; e_er = -1; e_ec = -1;
    for (int i = 0; i < 4; i++) begin
      ar[i] = 0; ac[i] = 0;
      for (int j = 0; j < 4; j++) begin
        ar[i] += m_z[i][j];
        ac[i] += m_z[j][i];
      end
      dr[i] = (m_er[i] & 32'h3ffff) - ar[i];
      dc[i] = (m_ec[i] & 32'h3ffff) - ac[i];
      if (dr[i] != 0) begin nr++; if (e_er < 0) e_er = i; end
      if (dc[i] != 0) begin nc++; if (e_ec < 0) e_ec = i; end
    end
    if (e_er < 0) e_er = 0;
    if (e_ec < 0) e_ec = 0;
    e_zc = m_z;
    v = m_z[e_er][e_ec] + dr[e_er];
    if (nr == 0 && nc == 0) e_st = 0;
    else if (nr == 1 && nc == 1 && dr[e_er] == dc[e_ec] && v >= 0 && v <= 65535) begin
      e_st = 1;
      e_zc[e_er][e_ec] = v;
    end else if (nr + nc == 1) e_st = 3;
    else e_st = 2;
  endtask

  function automatic logic [255:0] pack_ezc();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) p[DW*(4*i+j) +: DW] = 16'(e_zc[i][j]);
    return p;
  endfunction

  task automatic check_result(input string tag);
    model();
    chk({tag, ".status"}, 256'(status), 256'(e_st));
    chk({tag, ".err_row"}, 256'(err_row), 256'(e_er));
    chk({tag, ".err_col"}, 256'(err_col), 256'(e_ec));
    chk({tag, ".zc"}, 256'(zc_flat), pack_ezc());
  endtask

  // Wait for done after an accepted start; returns edges elapsed since acceptance
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input string tag);
    int lat;
    drive();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_on"}, 256'(busy), 256'(1));
    wait_done(lat);
    chk({tag, ".latency"}, 256'(lat), 256'(10));
    chk({tag, ".busy_in_done"}, 256'(busy), 256'(1));
    check_result(tag);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 256'(done), 256'(0));
    chk({tag, ".busy_off"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int lat, ndone, dlat, kind, r, c, off;
    rst = 1'b1; start = 1'b0; z_flat = '0; exp_row = '0; exp_col = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.zc", 256'(zc_flat), 256'(0));
    chk("reset.status", 256'(status), 256'(0));
    chk("reset.busy_done", 256'({busy, done, err_row, err_col}), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    load_ref(); run_op("clean");
    load_ref(); m_z[1][1] = 10; run_op("single");
    load_ref(); m_er[2] = 721; run_op("cksum_only");
    load_ref(); m_z[0][0] = 151; m_z[3][3] = 179; run_op("double");
    load_ref(); m_z[1][1] = 10; m_er[1] = 200; m_ec[1] = 200; run_op("oor_spec");
    load_ref(); m_z[0][0] = 5; m_er[0] = 745; m_ec[0] = 265; run_op("underflow");
    load_ref(); m_z[0][0] = 65530; exp_from_z(); m_er[0] += 10; m_ec[0] += 10; run_op("overflow");
    load_ref(); m_z[0][0] = 65530; exp_from_z(); m_z[0][0] = 65535; run_op("fix_to_max_down");

    // A second start during the operation is dropped
    load_ref(); drive();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    ndone = 0; dlat = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin ndone++; if (dlat == 0) dlat = k; end
    end
    chk("ignore.ndone", 256'(ndone), 256'(1));
    chk("ignore.lat", 256'(dlat), 256'(10));
    check_result("ignore");

    // Reset mid-operation aborts and clears results
    load_ref(); m_z[2][3] = 7; drive();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("midrst.zc", 256'(zc_flat), 256'(0));
    chk("midrst.flags", 256'({busy, done, status, err_row, err_col}), 256'(0));
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) ndone++; end
    chk("midrst.no_done", 256'(ndone), 256'(0));
    load_ref(); m_z[3][2] = 1000; run_op("after_rst");

    // Start in the done cycle is dropped; start in the next cycle is taken
    load_ref(); drive();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_done(lat);
    chk("b2b.first_lat", 256'(lat), 256'(10));
    load_ref(); m_z[2][0] = 3; drive();
    start = 1'b1; @(posedge clk); #1;
    chk("b2b.done_cycle_ignored", 256'(busy), 256'(0));
    @(posedge clk); #1; start = 1'b0;
    chk("b2b.accepted", 256'(busy), 256'(1));
    wait_done(lat);
    chk("b2b.second_lat", 256'(lat), 256'(10));
    check_result("b2b");
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Randomized fault injection
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          m_z[i][j] = (n % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
      exp_from_z();
      kind = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3)); c = int'($urandom_range(0, 3));
      off = int'($urandom_range(1, 5000));
      case (kind)
        1: m_z[r][c] = int'($urandom_range(0, 65535));
        2: if (off % 2 == 0) m_er[r] = (m_er[r] + off) & 32'h3ffff;
           else m_ec[c] = (m_ec[c] + off) & 32'h3ffff;
        3: begin
          m_z[r][c] = int'($urandom_range(0, 65535));
          m_z[int'($urandom_range(0, 3))][int'($urandom_range(0, 3))] = int'($urandom_range(0, 65535));
        end
        default: ;
      endcase
      run_op("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
